// File: rtl/dragon_body_queue.sv
// Dragon body segment queue.
//
// A shift queue of MAX_SEGMENTS body slots trailing the dragon head. The queue
// shifts once every MOVE_FRAMES vsync rising edges; the body length grows or
// shrinks by single-cycle requests and drives a thermometer display mask.
//
// Ports:
//   clk_i         system clock
//   rst_ni        asynchronous active-low reset
//   vsync_i       frame sync level, sampled on clk_i
//   grow_req_i    pulse: add one segment (saturates at MAX_SEGMENTS)
//   shrink_req_i  pulse: remove one segment (saturates at 0)
//   head_in_i     current head {orientation, position}
//   segments_o    flattened queue, slot k at [k*SEG_W +: SEG_W], slot 0 nearest head
//   display_en_o  bit k high when slot k is visible
//   length_o      current body length
//   move_tick_o   one-cycle pulse on the cycle the queue shifts
//   self_hit_o    one-cycle pulse after a move whose head hit a visible slot
//   full_o        length == MAX_SEGMENTS
//   empty_o       length == 0
module dragon_body_queue #(
  parameter int unsigned MAX_SEGMENTS = 8,
  parameter int unsigned POS_W        = 8,
  parameter int unsigned ORIENT_W     = 2,
  parameter int unsigned MOVE_FRAMES  = 10,
  parameter int unsigned INIT_LEN     = 0,
  localparam int unsigned SEG_W       = ORIENT_W + POS_W,
  localparam int unsigned LEN_W       = $clog2(MAX_SEGMENTS + 1)
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          vsync_i,
  input  logic                          grow_req_i,
  input  logic                          shrink_req_i,
  input  logic [SEG_W-1:0]              head_in_i,
  output logic [MAX_SEGMENTS*SEG_W-1:0] segments_o,
  output logic [MAX_SEGMENTS-1:0]       display_en_o,
  output logic [LEN_W-1:0]              length_o,
  output logic                          move_tick_o,
  output logic                          self_hit_o,
  output logic                          full_o,
  output logic                          empty_o
);

  localparam int unsigned CNT_W = (MOVE_FRAMES > 1) ? $clog2(MOVE_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CntLast = CNT_W'(MOVE_FRAMES - 1);
  localparam logic [LEN_W-1:0] LenMax  = LEN_W'(MAX_SEGMENTS);
  localparam logic [LEN_W-1:0] LenInit = LEN_W'(INIT_LEN);

  function automatic logic [MAX_SEGMENTS-1:0] therm(input logic [LEN_W-1:0] len);
    logic [MAX_SEGMENTS-1:0] t;
    for (int unsigned i = 0; i < MAX_SEGMENTS; i++) begin
      t[i] = (i < 32'(len));
    end
    return t;
  endfunction

  logic                                 vsync_q;
  logic                                 vsync_rise;
  logic [CNT_W-1:0]                     cnt_q, cnt_d;
  logic                                 tick_q, tick_d;
  logic                                 hit_q, hit_d;
  logic                                 hit_any;
  logic [MAX_SEGMENTS-1:0][SEG_W-1:0]   seg_q, seg_d;
  logic [LEN_W-1:0]                     len_q, len_d;
  logic [MAX_SEGMENTS-1:0]              disp_q, disp_d;

  assign vsync_rise = vsync_i & ~vsync_q;

  // Frame counter: the wrap edge schedules a move for the following cycle.
  always_comb begin
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (vsync_rise) begin
      if (cnt_q == CntLast) begin
        cnt_d  = '0;
        tick_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Collision uses pre-shift contents; orientation bits are ignored.
  always_comb begin
    hit_any = 1'b0;
    for (int unsigned k = 0; k < MAX_SEGMENTS; k++) begin
      if (disp_q[k] && (seg_q[k][POS_W-1:0] == head_in_i[POS_W-1:0])) begin
        hit_any = 1'b1;
      end
    end
  end

  assign hit_d = tick_q & hit_any;

  // Hidden slots still shift so a newly grown segment shows real history.
  always_comb begin
    seg_d = seg_q;
    if (tick_q) begin
      seg_d[0] = head_in_i;
      for (int unsigned k = 1; k < MAX_SEGMENTS; k++) begin
        seg_d[k] = seg_q[k-1];
      end
    end
  end

  // Simultaneous grow and shrink cancel; out-of-range requests are dropped.
  always_comb begin
    len_d = len_q;
    if (grow_req_i && !shrink_req_i && (len_q != LenMax)) begin
      len_d = len_q + LEN_W'(1);
    end else if (shrink_req_i && !grow_req_i && (len_q != '0)) begin
      len_d = len_q - LEN_W'(1);
    end
    disp_d = therm(len_d);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vsync_q <= 1'b0;
      cnt_q   <= '0;
      tick_q  <= 1'b0;
      hit_q   <= 1'b0;
      seg_q   <= '0;
      len_q   <= LenInit;
      disp_q  <= therm(LenInit);
    end else begin
      vsync_q <= vsync_i;
      cnt_q   <= cnt_d;
      tick_q  <= tick_d;
      hit_q   <= hit_d;
      seg_q   <= seg_d;
      len_q   <= len_d;
      disp_q  <= disp_d;
    end
  end

  assign segments_o   = seg_q;
  assign display_en_o = disp_q;
  assign length_o     = len_q;
  assign move_tick_o  = tick_q;
  assign self_hit_o   = hit_q;
  assign full_o       = (len_q == LenMax);
  assign empty_o      = (len_q == '0);

endmodule
